// File: rtl/rv32i_mini_soc.sv
// rv32i_mini_soc: single-cycle RV32I core with combinational-fetch ROM and byte-enabled data RAM.
// Build option: define DEBUG_HALT_EN to let uart_debug_pin freeze the core.

module tinyriscv_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : regs[raddr2];
endmodule

module tinyriscv #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);
    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpJal    = 7'h6f;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpReg    = 7'h33;
    localparam logic [6:0] OpSystem = 7'h73;

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] alu_b, alu_res;
    logic        is_op, op_legal, take;
    logic [31:0] ls_addr, load_val;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        store;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'h000};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    tinyriscv_regs u_regs (
        .clk    (clk),
        .rst    (rst),
        .we     (rd_we),
        .waddr  (instr[11:7]),
        .wdata  (rd_wdata),
        .raddr1 (instr[19:15]),
        .raddr2 (instr[24:20]),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign is_op    = (opcode == OpReg);
    // Only funct7 = 0 or SUB/SRA forms are real OP instructions; the rest run as NOPs.
    assign op_legal = (instr[31:25] == 7'h00) ||
                      ((instr[31:25] == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    always_comb begin
        alu_b = is_op ? rs2_val : imm_i;
        case (funct3)
            3'b000:  alu_res = (is_op && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << alu_b[4:0];
            3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'b0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = instr[30] ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                         : rs1_val >> alu_b[4:0];
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  take = (rs1_val == rs2_val);
            3'b001:  take = (rs1_val != rs2_val);
            3'b100:  take = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  take = (rs1_val < rs2_val);
            3'b111:  take = (rs1_val >= rs2_val);
            default: take = 1'b0;
        endcase
    end

    assign ls_addr = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);

    always_comb begin
        case (ls_addr[1:0])
            2'b00:   load_byte = mem_rdata[7:0];
            2'b01:   load_byte = mem_rdata[15:8];
            2'b10:   load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = ls_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_val = {{16{load_half[15]}}, load_half};
            3'b100:  load_val = {24'h0, load_byte};
            3'b101:  load_val = {16'h0, load_half};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                mem_be    = 4'b0001 << ls_addr[1:0];
                mem_wdata = {4{rs2_val[7:0]}};
            end
            2'b01: begin
                mem_be    = ls_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{rs2_val[15:0]}};
            end
            default: begin
                mem_be    = 4'b1111;
                mem_wdata = rs2_val;
            end
        endcase
    end

    always_comb begin
        rd_we    = 1'b0;
        rd_wdata = 32'h0;
        store    = 1'b0;
        pc_d     = pc_plus4;
        case (opcode)
            OpLui: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OpAuipc: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + imm_u;
            end
            OpJal: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = pc_q + imm_j;
            end
            OpJalr: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = (rs1_val + imm_i) & ~32'h1;
            end
            OpBranch: begin
                if (take) pc_d = pc_q + imm_b;
            end
            OpLoad: begin
                rd_we    = 1'b1;
                rd_wdata = load_val;
            end
            OpStore: store = 1'b1;
            OpImm: begin
                rd_we    = 1'b1;
                rd_wdata = alu_res;
            end
            OpReg: begin
                rd_we    = op_legal;
                rd_wdata = alu_res;
            end
            OpSystem: begin
                // CSR forms return 0; ECALL/EBREAK and friends fall through as NOPs.
                rd_we = (funct3 != 3'b000);
            end
            default: ;
        endcase
        if (halt) begin
            rd_we = 1'b0;
            store = 1'b0;
            pc_d  = pc_q;
        end
    end

    assign mem_addr = ls_addr;
    assign mem_we   = store;
endmodule

module soc_rom #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          load_en,
    input  logic [AW-1:0] load_idx,
    input  logic [31:0]   load_data,
    input  logic [AW-1:0] iidx,
    output logic [31:0]   idata,
    input  logic [AW-1:0] didx,
    output logic [31:0]   ddata
);
    logic [31:0] _rom [0:DEPTH-1];

    // Program loader port; the SoC ties it off and programs are preloaded before reset release.
    always_ff @(posedge clk) begin
        if (load_en) _rom[load_idx] <= load_data;
    end

    assign idata = _rom[iidx];
    assign ddata = _rom[didx];
endmodule

module soc_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];
endmodule

module rv32i_mini_soc #(
    parameter int unsigned ROM_DEPTH = 4096,
    parameter int unsigned RAM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst,
    input logic uart_debug_pin
);
    localparam int unsigned RomAw = $clog2(ROM_DEPTH);
    localparam int unsigned RamAw = $clog2(RAM_DEPTH);

    logic        halt;
    logic [31:0] pc, instr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rom_ddata, ram_rdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        rom_sel, ram_sel;
    logic        unused_addr;

`ifdef DEBUG_HALT_EN
    assign halt = uart_debug_pin;
`else
    logic unused_pin;
    assign halt       = 1'b0;
    assign unused_pin = uart_debug_pin;
`endif

    tinyriscv #(
        .RESET_PC (RESET_PC)
    ) u_tinyriscv (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .pc        (pc),
        .instr     (instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    soc_rom #(
        .DEPTH (ROM_DEPTH)
    ) u_rom (
        .clk       (clk),
        .load_en   (1'b0),
        .load_idx  ({RomAw{1'b0}}),
        .load_data (32'h0),
        .iidx      (pc[RomAw+1:2]),
        .idata     (instr),
        .didx      (mem_addr[RomAw+1:2]),
        .ddata     (rom_ddata)
    );

    assign rom_sel = (mem_addr[31:28] == 4'h0);
    assign ram_sel = (mem_addr[31:28] == 4'h1);

    // Gate with rst so an instruction in flight during reset never reaches the RAM.
    soc_ram #(
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we && ram_sel && rst),
        .be    (mem_be),
        .idx   (mem_addr[RamAw+1:2]),
        .wdata (mem_wdata),
        .rdata (ram_rdata)
    );

    assign mem_rdata   = rom_sel ? rom_ddata : (ram_sel ? ram_rdata : 32'h0);
    assign unused_addr = ^{pc, mem_addr};
endmodule

// File: tb/tb_rv32i_mini_soc.sv
// Directed bench for rv32i_mini_soc: small hand-assembled programs, results checked in x-registers.
module tb_rv32i_mini_soc;
    localparam logic [6:0] OP_IMM  = 7'h13;
    localparam logic [6:0] OP_LUI  = 7'h37;
    localparam logic [6:0] OP_AUI  = 7'h17;
    localparam logic [6:0] OP_LOAD = 7'h03;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_SYS  = 7'h73;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_debug_pin = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rv32i_mini_soc dut (
        .clk            (clk),
        .rst            (rst),
        .uart_debug_pin (uart_debug_pin)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xr(input int i);
        return dut.u_tinyriscv.u_regs.regs[i];
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    task automatic put(input int idx, input logic [31:0] w);
        dut.u_rom._rom[idx] <= w;
    endtask

    // Assert reset, fill the low ROM with self-loops so every program ends parked.
    task automatic begin_prog();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) put(i, 32'h0000_006f);
    endtask

    task automatic start_prog(input string tag);
        logic [31:0] acc;
        #40;
        acc = 32'h0;
        for (int i = 0; i < 32; i++) acc = acc | xr(i);
        check_eq({tag, "_rst_pc"}, dut.u_tinyriscv.pc, 32'h0);
        check_eq({tag, "_rst_regs"}, acc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_end(input string tag);
        for (int k = 0; k < 500 && xr(26) != 32'd1; k++) run(1);
        check_eq({tag, "_end_x26"}, xr(26), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ALU program
        begin_prog();
        put(0, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OP_IMM));
        put(1, enc_i(12'd28, 5'd1, 3'd5, 5'd2, OP_IMM));
        put(2, enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd4));
        put(3, enc_i(12'd5, 5'd0, 3'd0, 5'd0, OP_IMM));
        put(4, enc_i(12'h404, 5'd1, 3'd5, 5'd10, OP_IMM));
        put(5, enc_u(20'h80000, 5'd11, OP_LUI));
        put(6, enc_r(7'h00, 5'd2, 5'd11, 3'd2, 5'd12));
        put(7, enc_i(12'd33, 5'd0, 3'd0, 5'd13, OP_IMM));
        put(8, enc_r(7'h00, 5'd13, 5'd2, 3'd1, 5'd14));
        put(9, enc_r(7'h20, 5'd2, 5'd0, 3'd0, 5'd15));
        start_prog("alu");
        run(1);
        check_eq("alu_first_edge_x1", xr(1), 32'hFFFF_FFFF);
        check_eq("alu_first_edge_pc", dut.u_tinyriscv.pc, 32'h4);
        run(14);
        check_eq("alu_srli_x2", xr(2), 32'h0000_000F);
        check_eq("alu_sltu_x4", xr(4), 32'h1);
        check_eq("alu_x0", xr(0), 32'h0);
        check_eq("alu_srai_x10", xr(10), 32'hFFFF_FFFF);
        check_eq("alu_lui_x11", xr(11), 32'h8000_0000);
        check_eq("alu_slt_x12", xr(12), 32'h1);
        check_eq("alu_sll33_x14", xr(14), 32'h0000_001E);
        check_eq("alu_sub_x15", xr(15), 32'hFFFF_FFF1);
        check_eq("alu_park_pc", dut.u_tinyriscv.pc, 32'd40);

        // Memory program
        begin_prog();
        put(0, enc_u(20'h10000, 5'd5, OP_LUI));
        put(1, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OP_IMM));
        put(2, enc_s(12'd0, 5'd1, 5'd5, 3'd2));
        put(3, enc_s(12'd1, 5'd0, 5'd5, 3'd0));
        put(4, enc_i(12'd0, 5'd5, 3'd2, 5'd6, OP_LOAD));
        put(5, enc_i(12'd3, 5'd5, 3'd0, 5'd7, OP_LOAD));
        put(6, enc_i(12'd0, 5'd5, 3'd5, 5'd8, OP_LOAD));
        put(7, enc_s(12'd0, 5'd1, 5'd0, 3'd2));
        put(8, enc_i(12'd0, 5'd0, 3'd2, 5'd15, OP_LOAD));
        put(9, enc_i(12'h123, 5'd0, 3'd0, 5'd16, OP_IMM));
        put(10, enc_s(12'd1, 5'd16, 5'd5, 3'd1));
        put(11, enc_i(12'd0, 5'd5, 3'd2, 5'd17, OP_LOAD));
        put(12, enc_i(12'd2, 5'd5, 3'd1, 5'd18, OP_LOAD));
        put(13, enc_i(12'd0, 5'd5, 3'd4, 5'd19, OP_LOAD));
        put(14, enc_u(20'h20000, 5'd20, OP_LUI));
        put(15, enc_i(12'hFFF, 5'd0, 3'd0, 5'd21, OP_IMM));
        put(16, enc_i(12'd0, 5'd20, 3'd2, 5'd21, OP_LOAD));
        start_prog("mem");
        run(25);
        check_eq("mem_lw_x6", xr(6), 32'hFFFF_00FF);
        check_eq("mem_lb_x7", xr(7), 32'hFFFF_FFFF);
        check_eq("mem_lhu_x8", xr(8), 32'h0000_00FF);
        check_eq("mem_rom_intact", dut.u_rom._rom[0], 32'h1000_02B7);
        check_eq("mem_rom_load_x15", xr(15), 32'h1000_02B7);
        check_eq("mem_sh_odd_x17", xr(17), 32'hFFFF_0123);
        check_eq("mem_lh_x18", xr(18), 32'hFFFF_FFFF);
        check_eq("mem_lbu_x19", xr(19), 32'h0000_0023);
        check_eq("mem_unmapped_x21", xr(21), 32'h0);

        // Asynchronous reset mid-cycle clears state without waiting for an edge
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_x6", xr(6), 32'h0);
        check_eq("async_rst_pc", dut.u_tinyriscv.pc, 32'h0);

        // Control-flow program
        begin_prog();
        put(0, enc_i(12'd0, 5'd0, 3'd0, 5'd9, OP_IMM));
        put(1, enc_i(12'd10, 5'd0, 3'd0, 5'd22, OP_IMM));
        put(2, enc_i(12'd1, 5'd9, 3'd0, 5'd9, OP_IMM));
        put(3, enc_b(13'h1FFC, 5'd22, 5'd9, 3'd1));
        put(4, enc_j(21'd8, 5'd1));
        put(5, enc_i(12'd1, 5'd0, 3'd0, 5'd23, OP_IMM));
        put(6, enc_i(12'd41, 5'd0, 3'd0, 5'd24, OP_IMM));
        put(7, enc_i(12'd0, 5'd24, 3'd0, 5'd25, OP_JALR));
        put(8, enc_i(12'd2, 5'd0, 3'd0, 5'd23, OP_IMM));
        put(9, enc_i(12'd3, 5'd0, 3'd0, 5'd23, OP_IMM));
        put(10, enc_i(12'd5, 5'd0, 3'd0, 5'd28, OP_IMM));
        put(11, enc_i(12'hFFE, 5'd0, 3'd0, 5'd29, OP_IMM));
        put(12, enc_b(13'd8, 5'd0, 5'd29, 3'd5));
        put(13, enc_i(12'd1, 5'd0, 3'd0, 5'd30, OP_IMM));
        put(14, enc_b(13'd8, 5'd29, 5'd0, 3'd6));
        put(15, enc_i(12'd9, 5'd0, 3'd0, 5'd30, OP_IMM));
        put(16, enc_u(20'd1, 5'd31, OP_AUI));
        start_prog("ctl");
`ifdef DEBUG_HALT_EN
        run(7);
        check_eq("halt_pre_pc", dut.u_tinyriscv.pc, 32'd12);
        check_eq("halt_pre_x9", xr(9), 32'd3);
        @(negedge clk);
        uart_debug_pin = 1'b1;
        for (int c = 0; c < 5; c++) begin
            run(1);
            check_eq("halt_pc_held", dut.u_tinyriscv.pc, 32'd12);
            check_eq("halt_x9_held", xr(9), 32'd3);
        end
        @(negedge clk);
        uart_debug_pin = 1'b0;
`endif
        run(80);
        check_eq("ctl_loop_x9", xr(9), 32'd10);
        check_eq("ctl_jal_link_x1", xr(1), 32'd20);
        check_eq("ctl_skipped_x23", xr(23), 32'd0);
        check_eq("ctl_jalr_link_x25", xr(25), 32'd32);
        check_eq("ctl_jalr_odd_x28", xr(28), 32'd5);
        check_eq("ctl_bge_bltu_x30", xr(30), 32'd1);
        check_eq("ctl_auipc_x31", xr(31), 32'h0000_1040);
        check_eq("ctl_park_pc", dut.u_tinyriscv.pc, 32'd68);

        // Passing self-check program, with CSR and ECALL on the way
        begin_prog();
        put(0, enc_i(12'd1, 5'd0, 3'd0, 5'd5, OP_IMM));
        put(1, enc_i(12'h300, 5'd0, 3'd2, 5'd5, OP_SYS));
        put(2, 32'h0000_0073);
        put(3, enc_i(12'd1, 5'd0, 3'd0, 5'd27, OP_IMM));
        put(4, enc_i(12'd1, 5'd0, 3'd0, 5'd26, OP_IMM));
        start_prog("pass");
        wait_end("pass");
        check_eq("pass_x27", xr(27), 32'd1);
        check_eq("pass_csr_x5", xr(5), 32'd0);

        // Failing self-check variant: bench must see the failure verdict and number
        begin_prog();
        put(0, enc_i(12'd7, 5'd0, 3'd0, 5'd3, OP_IMM));
        put(1, enc_i(12'd0, 5'd0, 3'd0, 5'd27, OP_IMM));
        put(2, enc_i(12'd1, 5'd0, 3'd0, 5'd26, OP_IMM));
        start_prog("fail");
        wait_end("fail");
        check_eq("fail_x27", xr(27), 32'd0);
        check_eq("fail_x3", xr(3), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
